// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory request/response
// handshake, and the IF/ID pipeline register. A two-state FSM (FETCH/DRAIN)
// discards a stale memory response that was still outstanding when a branch
// redirected the fetch stream.
module fetch_stage #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  pc_id,
  output logic [INSTR_W-1:0] instr_id,
  output logic               valid_id
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [ADDR_W-1:0]    pc_id_q, pc_id_d;
  logic [INSTR_W-1:0]   instr_id_q, instr_id_d;
  logic                 valid_id_q, valid_id_d;
  logic [ADDR_W-1:0]    pc_plus4;

  // Sequential PC increment; wraps modulo 2^ADDR_W by construction.
  assign pc_plus4 = pc_q + ADDR_W'(4);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: a redirect with no response in the same cycle leaves a
  // stale request in flight, so DRAIN until memory answers it.
  always_comb begin
    state_d = state_q;
    if (branch_taken) begin
      state_d = imem_ready ? S_FETCH : S_DRAIN;
    end else if (state_q == S_DRAIN) begin
      if (imem_ready) begin
        state_d = S_FETCH;
      end
    end
  end

  // FSM outputs: request only while fetching; the address is always the PC.
  always_comb begin
    imem_req  = (state_q == S_FETCH);
    imem_addr = pc_q;
  end

  // Next PC and IF/ID contents, in priority order: redirect, drain, freeze,
  // accepted response, memory wait.
  always_comb begin
    pc_d       = pc_q;
    pc_id_d    = pc_id_q;
    instr_id_d = instr_id_q;
    valid_id_d = valid_id_q;
    if (branch_taken) begin
      // Redirect beats freeze; the newest target always wins.
      pc_d       = branch_addr;
      pc_id_d    = '0;
      instr_id_d = '0;
      valid_id_d = 1'b0;
    end else if (state_q == S_DRAIN) begin
      // Stale response is never written; insert a bubble unless ID is frozen.
      if (!freeze) begin
        instr_id_d = '0;
        valid_id_d = 1'b0;
      end
    end else if (freeze) begin
      // Hold everything; a response arriving now is dropped and the same PC
      // stays on the bus to be re-requested.
    end else if (imem_ready) begin
      pc_d       = pc_plus4;
      pc_id_d    = pc_plus4;
      instr_id_d = imem_rdata;
      valid_id_d = 1'b1;
    end else begin
      // Memory wait state: PC (and therefore imem_addr) must stay stable.
      instr_id_d = '0;
      valid_id_d = 1'b0;
    end
  end

  // PC and IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      pc_id_q    <= '0;
      instr_id_q <= '0;
      valid_id_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_id_q    <= pc_id_d;
      instr_id_q <= instr_id_d;
      valid_id_q <= valid_id_d;
    end
  end

  assign pc_id    = pc_id_q;
  assign instr_id = instr_id_q;
  assign valid_id = valid_id_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by randomized
// stimulus, checked by a queue-based scoreboard against a reference model.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc_id;
  logic [31:0] instr_id;
  logic        valid_id;

  fetch_stage #(
    .ADDR_W  (32),
    .INSTR_W (32),
    .RESET_PC(32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .pc_id       (pc_id),
    .instr_id    (instr_id),
    .valid_id    (valid_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] ins;
    logic [31:0] pcid;
    logic        pchk;
    logic        req;
    logic [31:0] addr;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model state: architectural PC, whether a stale response is
  // still owed, and the contents the ID stage should be holding.
  logic [31:0] m_pc    = 32'h0;
  logic        m_drain = 1'b0;
  logic        m_v     = 1'b0;
  logic [31:0] m_ins   = 32'h0;
  logic [31:0] m_pcid  = 32'h0;
  logic        m_pk    = 1'b1;

  // Instruction memory contents as a function of address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
  endfunction

  // One clock of stimulus; updates the model and pushes the response
  // expected right after the coming rising edge.
  task automatic cyc(input logic r, input logic f, input logic b,
                     input logic [31:0] ba, input logic rdy, input logic dead);
    exp_t e;
    @(negedge clk);
    rst          = r;
    freeze       = f;
    branch_taken = b;
    branch_addr  = ba;
    imem_ready   = rdy;
    imem_rdata   = (dead && m_drain) ? 32'h0000_DEAD : memf(imem_addr);
    if (r) begin
      m_pc = 32'h0; m_drain = 1'b0;
      m_v = 1'b0; m_ins = 32'h0; m_pcid = 32'h0; m_pk = 1'b1;
    end else if (b) begin
      m_pc = ba; m_drain = !rdy;
      m_v = 1'b0; m_ins = 32'h0; m_pcid = 32'h0; m_pk = 1'b1;
    end else if (m_drain) begin
      if (!f) begin m_v = 1'b0; m_ins = 32'h0; m_pk = 1'b0; end
      if (rdy) m_drain = 1'b0;
    end else if (f) begin
      // everything holds
    end else if (rdy) begin
      m_v = 1'b1; m_ins = memf(m_pc); m_pcid = m_pc + 32'd4; m_pk = 1'b1;
      m_pc = m_pc + 32'd4;
    end else begin
      m_v = 1'b0; m_ins = 32'h0; m_pk = 1'b0;
    end
    e.v = m_v; e.ins = m_ins; e.pcid = m_pcid; e.pchk = m_pk;
    e.req = !m_drain; e.addr = m_pc;
    q.push_back(e);
  endtask

  // Monitor: the DUT presents a new IF/ID + request every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("valid_id", 32'(valid_id), 32'(e.v));
        chk("instr_id", instr_id, e.ins);
        if (e.pchk) chk("pc_id", pc_id, e.pcid);
        chk("imem_req", 32'(imem_req), 32'(e.req));
        chk("imem_addr", imem_addr, e.addr);
      end
    end
  end

  initial begin
    logic [31:0] ba;
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0;
    branch_addr = 32'h0; imem_ready = 1'b0; imem_rdata = 32'h0;

    // Reset, then zero-wait streaming from 0.
    repeat (2) cyc(1, 0, 0, 0, 1, 0);
    repeat (4) cyc(0, 0, 0, 0, 1, 0);
    // Freeze two cycles at PC=0x10, then resume.
    repeat (2) cyc(0, 1, 0, 0, 1, 0);
    repeat (4) cyc(0, 0, 0, 0, 1, 0);
    // Three wait states at PC=0x20.
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    repeat (8) cyc(0, 0, 0, 0, 1, 0);
    // Branch with ready=1 at PC=0x40.
    cyc(0, 0, 1, 32'h100, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 1, 0);
    // Back to 0x40, then branch with the fetch outstanding.
    cyc(0, 0, 1, 32'h40, 1, 0);
    cyc(0, 0, 1, 32'h200, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 1);
    repeat (2) cyc(0, 0, 0, 0, 1, 0);
    // Second branch during DRAIN wins.
    cyc(0, 0, 1, 32'h400, 0, 0);
    cyc(0, 0, 1, 32'h300, 0, 1);
    cyc(0, 0, 0, 0, 1, 1);
    repeat (2) cyc(0, 0, 0, 0, 1, 0);
    // Branch together with freeze; DRAIN with freeze holds IF/ID.
    cyc(0, 1, 1, 32'h500, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 32'h600, 0, 0);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 0);
    // Reset during DRAIN; reset beats branch.
    cyc(0, 0, 1, 32'h700, 0, 0);
    cyc(1, 0, 1, 32'h800, 1, 1);
    repeat (2) cyc(0, 0, 0, 0, 1, 0);
    // Wrap from 0xFFFFFFFC to 0.
    cyc(0, 0, 1, 32'hFFFF_FFF8, 1, 0);
    repeat (4) cyc(0, 0, 0, 0, 1, 0);
    // Freeze with a stalled memory.
    repeat (2) cyc(0, 1, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      ba = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4))
                                       : ($urandom & 32'hFFFF_FFFC);
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 11) == 0), ba, ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 1) == 0));
    end

    @(posedge clk);
    #2;
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage ARM pipeline. It includes the PC register, the instruction-memory request/response handshake and the IF/ID pipeline register.
- It consumes `freeze` from the hazard detection unit and the branch redirect from EXE.
- It produces the instruction, PC+4 and valid bit consumed by the ID stage.
- Stale memory responses after a redirect are discarded through a two-state drain FSM.

Parameters:
- ADDR_W, 32, width of PC and memory address
- INSTR_W, 32, instruction width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- freeze  in  1  from hazard detection unit; hold PC and IF/ID
- branch_taken  in  1  from EXE; redirect fetch, flush IF/ID
- branch_addr  in  ADDR_W  redirect target
- imem_req  out  1  fetch request valid
- imem_addr  out  ADDR_W  fetch address (always equals PC)
- imem_ready  in  1  response valid for the outstanding request
- imem_rdata  in  INSTR_W  instruction data, valid when imem_ready
- pc_id  out  ADDR_W  IF/ID: PC+4 of held instruction
- instr_id  out  INSTR_W  IF/ID: instruction
- valid_id  out  1  IF/ID: instruction valid (0 = bubble)

Behaviour:
Clock and reset:
- One clock (`clk`). Reset `rst` is synchronous and active-high.

Reset values:
- PC=RESET_PC, state=FETCH.
- pc_id=0, instr_id=0, valid_id=0.
- imem_req=1 from the first cycle after reset.
- rst mid-operation overrides everything, including any outstanding request. Memory is reset on the same `rst`.

Handshake:
- imem_req=1 in FETCH, 0 in DRAIN.
- imem_addr=PC combinationally.
- While imem_req=1 and imem_ready=0, imem_addr must not change. The PC is therefore only written on an accepted response or a redirect.
- imem_ready is only sampled as a new instruction in FETCH.

FSM states:
- FETCH: request outstanding for PC.
- DRAIN: a stale request is outstanding, and its response must be discarded.

Per-cycle priority (highest first):
1. branch_taken, state FETCH:
   - PC<=branch_addr.
   - IF/ID flushed: valid_id<=0, instr_id<=0, pc_id<=0.
   - If imem_ready=1: response dropped, stay FETCH.
   - If imem_ready=0: go to DRAIN.
   - Takes precedence over freeze.
2. branch_taken, state DRAIN:
   - PC<=branch_addr (newest target wins).
   - IF/ID flushed.
   - If imem_ready=1: go to FETCH.
   - Otherwise stay DRAIN.
3. DRAIN, no branch:
   - IF/ID: if freeze, hold; else flush to bubble.
   - On imem_ready=1: response discarded, go to FETCH.
4. FETCH, freeze=1:
   - PC and IF/ID hold.
   - A response arriving this cycle is discarded. The same PC is re-requested next cycle, with no skid buffer.
5. FETCH, imem_ready=1, no freeze:
   - instr_id<=imem_rdata, pc_id<=PC+4, valid_id<=1.
   - PC<=PC+4.
6. FETCH, imem_ready=0, no freeze:
   - PC holds; IF/ID becomes bubble (valid_id<=0, instr_id<=0).

Latency and arithmetic:
- Instruction available at ID one cycle after the imem_ready cycle.
- Zero-wait memory gives one instruction per cycle.
- PC+4 is modulo 2^ADDR_W: wrap from 0xFFFFFFFC to 0 is legal and silent.
- branch_addr is used as given (no alignment check).

Boundary cases:
- Freeze together with a stalled memory: PC holds, IF/ID holds, no bubble inserted.
- Branch in the same cycle as reset: reset wins.
- No response is ever written to IF/ID in DRAIN.

Test Plan:
1. Reset, imem_ready=1 constantly, rdata=addr-derived:
   - imem_addr goes 0,4,8,…
   - valid_id=1 from cycle 2; pc_id=4,8,12 with matching instr_id.
2. Freeze while streaming:
   - Freeze high 2 cycles at PC=0x10: imem_addr stays 0x10 and IF/ID holds pc_id=0x10.
   - After release, instr at 0x10 arrives with pc_id=0x14; no instruction lost or duplicated.
3. Memory wait states:
   - imem_ready low 3 cycles at PC=0x20: imem_addr stable at 0x20 and valid_id=0 for 3 cycles.
   - Then instr_id=rdata, pc_id=0x24.
4. Branch with ready=1:
   - branch_taken, branch_addr=0x100 at PC=0x40: next imem_addr=0x100, valid_id=0, state FETCH.
   - Next instruction carries pc_id=0x104.
5. Branch during outstanding fetch:
   - At PC=0x40 with ready=0, branch to 0x200: imem_req=0 (DRAIN).
   - Late ready with rdata=0xDEAD is not written to IF/ID.
   - Then request 0x200 resumes.
   - A second branch to 0x300 during DRAIN makes 0x300 win.
6. Branch+freeze and mid-run reset:
   - branch_taken with freeze=1 flushes IF/ID and redirects.
   - rst asserted during DRAIN returns PC=0, FETCH, valid_id=0 on the next edge.
   - Wrap case: PC=0xFFFFFFFC advances to 0.
